// File: rtl/ret_pop_state_machine.sv
// rtl/ret_pop_state_machine.sv - RET/RTI stack-pop sequencer: restores flags and PC one word per cycle
module ret_pop_state_machine #(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 16,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ret_start_i,
    input  logic                  rti_start_i,
    input  logic                  flush_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic                  pop_en_o,
    output logic                  stall_o,
    output logic [PC_WIDTH-1:0]   pc_out_o,
    output logic                  pc_valid_o,
    output logic [FLAG_WIDTH-1:0] flags_out_o,
    output logic                  flags_valid_o
);

    localparam int NW = PC_WIDTH / WORD_WIDTH;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    generate
        if ((PC_WIDTH % WORD_WIDTH) != 0 || PC_WIDTH < WORD_WIDTH) begin : g_bad_pc_width
            $error("PC_WIDTH must be a positive multiple of WORD_WIDTH");
        end
        if (FLAG_WIDTH > WORD_WIDTH || FLAG_WIDTH < 1) begin : g_bad_flag_width
            $error("FLAG_WIDTH must be between 1 and WORD_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        POP_FLAGS = 2'd1,
        POP_PC    = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rti_q, rti_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;
    logic                  pop_en_q, pc_valid_q, flags_valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rti_d   = rti_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (rti_start_i) begin
                    state_d = POP_FLAGS;
                    rti_d   = 1'b1;
                end else if (ret_start_i) begin
                    state_d = POP_PC;
                    rti_d   = 1'b0;
                    cnt_d   = CW'(NW - 1);
                end
            end
            POP_FLAGS: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    flags_d = mem_rdata_i[FLAG_WIDTH-1:0];
                    cnt_d   = CW'(NW - 1);
                    state_d = POP_PC;
                end
            end
            POP_PC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    // Shift in MSW first; for NW==1 the shift clears pc_q entirely.
                    pc_d = (pc_q << WORD_WIDTH) | PC_WIDTH'(mem_rdata_i);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they stay pure Moore decodes.
    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rti_q         <= 1'b0;
            pc_q          <= '0;
            flags_q       <= '0;
            pop_en_q      <= 1'b0;
            pc_valid_q    <= 1'b0;
            flags_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rti_q         <= rti_d;
            pc_q          <= pc_d;
            flags_q       <= flags_d;
            pop_en_q      <= (state_d == POP_FLAGS) || (state_d == POP_PC);
            pc_valid_q    <= (state_d == DONE);
            flags_valid_q <= (state_d == DONE) && rti_d;
        end
    end

    assign pop_en_o      = pop_en_q;
    assign stall_o       = pop_en_q;
    assign pc_out_o      = pc_q;
    assign pc_valid_o    = pc_valid_q;
    assign flags_out_o   = flags_q;
    assign flags_valid_o = flags_valid_q;

endmodule

// File: tb/tb_ret_pop_state_machine.sv
// tb/tb_ret_pop_state_machine.sv - schedule-based reference model bench for ret_pop_state_machine
module tb_ret_pop_state_machine;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        ret_start_i = 1'b0;
    logic        rti_start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [15:0] mem_rdata_i = 16'h0;
    logic        pop_en_o, stall_o, pc_valid_o, flags_valid_o;
    logic [31:0] pc_out_o;
    logic [3:0]  flags_out_o;

    ret_pop_state_machine #(.PC_WIDTH(32), .WORD_WIDTH(16), .FLAG_WIDTH(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ret_start_i(ret_start_i), .rti_start_i(rti_start_i),
        .flush_i(flush_i), .mem_rdata_i(mem_rdata_i), .pop_en_o(pop_en_o), .stall_o(stall_o),
        .pc_out_o(pc_out_o), .pc_valid_o(pc_valid_o), .flags_out_o(flags_out_o),
        .flags_valid_o(flags_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int pop_cnt = 0;
    int pv_cnt  = 0;

    // Model: a queue of upcoming cycles. 0 = flags pop, 1 = PC word pop, 2 = RET done, 3 = RTI done.
    int          sched[$];
    logic [31:0] m_pc = 32'h0;
    logic [3:0]  m_flags = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_i) begin
            sched.delete();
            m_pc    = 32'h0;
            m_flags = 4'h0;
        end else if (sched.size() != 0) begin
            if (flush_i) begin
                sched.delete();
            end else begin
                if (sched[0] == 0) m_flags = mem_rdata_i[3:0];
                if (sched[0] == 1) m_pc = {m_pc[15:0], mem_rdata_i};
                void'(sched.pop_front());
            end
        end else if (!flush_i) begin
            if (rti_start_i)      sched = '{0, 1, 1, 3};
            else if (ret_start_i) sched = '{1, 1, 2};
        end
    end

    always @(posedge clk_i) begin
        int k;
        k = (sched.size() != 0) ? sched[0] : -1;
        chk("pop_en",      {31'b0, pop_en_o},      {31'b0, (k == 0 || k == 1)});
        chk("stall",       {31'b0, stall_o},       {31'b0, (k == 0 || k == 1)});
        chk("pc_valid",    {31'b0, pc_valid_o},    {31'b0, (k >= 2)});
        chk("flags_valid", {31'b0, flags_valid_o}, {31'b0, (k == 3)});
        chk("pc_out",      pc_out_o,               m_pc);
        chk("flags_out",   {28'b0, flags_out_o},   {28'b0, m_flags});
        if (pop_en_o === 1'b1)   pop_cnt++;
        if (pc_valid_o === 1'b1) pv_cnt++;
    end

    task automatic drive(input logic r, input logic t, input logic f, input logic [15:0] d);
        @(posedge clk_i);
        #1;
        ret_start_i = r;
        rti_start_i = t;
        flush_i     = f;
        mem_rdata_i = d;
    endtask

    task automatic at_next_posedge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1 reset_i = 1'b1;
        #1;
        chk("reset_pc", pc_out_o, 32'h0);
        chk("reset_pop", {31'b0, pop_en_o}, 32'h0);
        repeat (2) drive(0, 0, 0, 16'h0);
        reset_i = 1'b0;
        repeat (2) drive(0, 0, 0, 16'h0);

        pop_cnt = 0; pv_cnt = 0;
        drive(1, 0, 0, 16'hFFFF);
        drive(0, 0, 0, 16'h0012);
        drive(0, 0, 0, 16'h3456);
        at_next_posedge();
        chk("ret_pc", pc_out_o, 32'h0012_3456);
        chk("ret_pv", {31'b0, pc_valid_o}, 32'h1);
        chk("ret_fv", {31'b0, flags_valid_o}, 32'h0);
        chk("ret_pops", pop_cnt, 2);
        drive(0, 0, 0, 16'h0);
        at_next_posedge();
        chk("ret_pulses", pv_cnt, 1);

        pop_cnt = 0;
        drive(0, 1, 0, 16'hFFFF);
        drive(0, 0, 0, 16'h000A);
        drive(0, 0, 0, 16'h0000);
        drive(0, 0, 0, 16'h0100);
        at_next_posedge();
        chk("rti_pc", pc_out_o, 32'h0000_0100);
        chk("rti_flags", {28'b0, flags_out_o}, 32'hA);
        chk("rti_pv", {31'b0, pc_valid_o}, 32'h1);
        chk("rti_fv", {31'b0, flags_valid_o}, 32'h1);
        chk("rti_pops", pop_cnt, 3);
        drive(0, 0, 0, 16'h0);

        pop_cnt = 0;
        drive(1, 1, 0, 16'hFFFF);
        drive(0, 0, 0, 16'h0005);
        drive(0, 0, 0, 16'h1234);
        drive(0, 0, 0, 16'h5678);
        at_next_posedge();
        chk("both_pc", pc_out_o, 32'h1234_5678);
        chk("both_flags", {28'b0, flags_out_o}, 32'h5);
        chk("both_fv", {31'b0, flags_valid_o}, 32'h1);
        chk("both_pops", pop_cnt, 3);
        drive(0, 0, 0, 16'h0);

        pv_cnt = 0;
        drive(1, 0, 0, 16'hFFFF);
        drive(0, 0, 0, 16'hBEEF);
        at_next_posedge();
        reset_i = 1'b1;
        #1;
        chk("abort_rst_pc", pc_out_o, 32'h0);
        chk("abort_rst_pop", {31'b0, pop_en_o}, 32'h0);
        chk("abort_rst_stall", {31'b0, stall_o}, 32'h0);
        chk("abort_rst_flags", {28'b0, flags_out_o}, 32'h0);
        drive(0, 0, 0, 16'h0);
        reset_i = 1'b0;
        drive(1, 0, 0, 16'hFFFF);
        drive(0, 0, 0, 16'hCAFE);
        drive(0, 0, 1, 16'h1111);
        drive(0, 0, 0, 16'h0);
        chk("flush_pc", pc_out_o, 32'h0000_CAFE);
        chk("flush_pop", {31'b0, pop_en_o}, 32'h0);
        repeat (3) drive(0, 0, 0, 16'h0);
        chk("abort_no_pulse", pv_cnt, 0);

        pv_cnt = 0; pop_cnt = 0;
        repeat (5) drive(1, 0, 0, 16'h2222);
        repeat (6) drive(0, 0, 0, 16'h0);
        chk("held_pulses", pv_cnt, 2);
        chk("held_pops", pop_cnt, 4);

        pv_cnt = 0; pop_cnt = 0;
        drive(1, 0, 0, 16'h3333);
        drive(0, 0, 0, 16'h4444);
        drive(0, 0, 0, 16'h5555);
        drive(1, 0, 0, 16'h6666);
        repeat (5) drive(0, 0, 0, 16'h0);
        chk("done_pulse_ignored", pv_cnt, 1);
        chk("done_pulse_pops", pop_cnt, 2);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 11) == 0), 16'($urandom));
            reset_i = ($urandom_range(0, 199) == 0);
        end
        drive(0, 0, 0, 16'h0);
        reset_i = 1'b0;
        repeat (6) drive(0, 0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
